// File: rtl/bloom_query_engine.sv
// Bloom-filter query engine: HASHES_CNT single-bit LUT banks probed in a two-stage pipeline;
// strings that hit every bank are counted and queued in a show-ahead suspect FIFO.
module bloom_query_engine #(
  parameter int BYTE_W      = 8,
  parameter int STR_SIZE    = 20,
  parameter int HASHES_CNT  = 6,
  parameter int HASH_W      = 12,
  parameter int MATCH_CNT_W = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int AMM_ADDR_W  = 32,
  parameter int AMM_DATA_W  = 32
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  input  logic [STR_SIZE*BYTE_W-1:0]     data_i,
  input  logic [HASHES_CNT*HASH_W-1:0]   hash_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [AMM_ADDR_W-1:0]          amm_address_i,
  input  logic                           amm_write_i,
  input  logic [AMM_DATA_W-1:0]          amm_writedata_i,
  output logic [MATCH_CNT_W-1:0]         matches_cnt_o,
  input  logic                           matches_cnt_clean_stb_i,
  output logic [STR_SIZE*BYTE_W-1:0]     suspect_data_o,
  output logic                           suspect_valid_o,
  input  logic                           suspect_ready_i,
  output logic                           busy_o
);

  localparam int DATA_W = STR_SIZE * BYTE_W;
  localparam int LUT_DEPTH = 2 ** HASH_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                         state_reg, state_next;
  logic [HASH_W-1:0]              clr_cnt_reg, clr_cnt_next;
  logic                           run_reg;
  logic                           s0_valid_reg, s1_valid_reg;
  logic [DATA_W-1:0]              s0_data_reg, s1_data_reg;
  logic [HASHES_CNT*HASH_W-1:0]   s0_hash_reg;
  logic [HASHES_CNT-1:0]          rd_bits;
  logic [PTR_W:0]                 wr_ptr_reg, rd_ptr_reg, fifo_used;
  logic [PTR_W+1:0]               occupancy;
  logic [1:0]                     inflight;
  logic [MATCH_CNT_W-1:0]         cnt_reg;
  logic [DATA_W-1:0]              fifo_mem [FIFO_DEPTH];
  logic                           accept, push, pop;
  logic                           cmd_clear, lut_we, clear_we;
  logic [3:0]                     bank_sel;
  logic [HASH_W-1:0]              lut_idx;
  logic                           unused_bits;

  assign unused_bits = ^{amm_address_i, amm_writedata_i};

  // Top address bit selects bulk clear; LUT traffic is only honoured in IDLE.
  assign cmd_clear = amm_write_i && amm_address_i[AMM_ADDR_W-1] && (state_reg == IDLE);
  assign lut_we    = amm_write_i && !amm_address_i[AMM_ADDR_W-1] && (state_reg == IDLE);
  assign clear_we  = (state_reg == CLEAR);
  assign bank_sel  = amm_address_i[HASH_W +: 4];
  assign lut_idx   = amm_address_i[HASH_W-1:0];

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_clear) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == {HASH_W{1'b1}}) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg   <= IDLE;
      clr_cnt_reg <= '0;
      run_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      run_reg     <= 1'b1;
    end
  end

  // Bank read is registered, so a same-edge write leaves the query with the old bit.
  generate
    for (genvar gi = 0; gi < HASHES_CNT; gi++) begin : g_bank
      logic lut_mem [LUT_DEPTH];
      logic rd_bit_reg;
      always_ff @(posedge clk_i) begin
        if (clear_we)
          lut_mem[clr_cnt_reg] <= 1'b0;
        else if (lut_we && (bank_sel == 4'(gi)))
          lut_mem[lut_idx] <= amm_writedata_i[0];
        rd_bit_reg <= lut_mem[s0_hash_reg[gi*HASH_W +: HASH_W]];
      end
      assign rd_bits[gi] = rd_bit_reg;
    end
  endgenerate

  assign accept    = valid_i && ready_o;
  assign push      = s1_valid_reg && (&rd_bits);
  assign pop       = suspect_valid_o && suspect_ready_i;
  assign fifo_used = wr_ptr_reg - rd_ptr_reg;
  assign inflight  = {1'b0, s0_valid_reg} + {1'b0, s1_valid_reg};
  assign occupancy = {1'b0, fifo_used} + {{PTR_W{1'b0}}, inflight};

  // Reserving FIFO room for every in-flight query means a push never finds it full.
  assign ready_o         = run_reg && (state_reg == IDLE) && (occupancy < (PTR_W+2)'(FIFO_DEPTH));
  assign suspect_valid_o = (fifo_used != '0);
  assign suspect_data_o  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
  assign busy_o          = (state_reg == CLEAR);
  assign matches_cnt_o   = cnt_reg;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s0_valid_reg <= 1'b0;
      s0_data_reg  <= '0;
      s0_hash_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s0_valid_reg <= accept;
      if (accept) begin
        s0_data_reg <= data_i;
        s0_hash_reg <= hash_i;
      end
      s1_valid_reg <= s0_valid_reg;
      s1_data_reg  <= s0_data_reg;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (matches_cnt_clean_stb_i)
        cnt_reg <= '0;
      else if (push && (cnt_reg != {MATCH_CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= s1_data_reg;
  end

endmodule

// File: tb/tb_bloom_query_engine.sv
// Directed bench for bloom_query_engine: table of single queries plus hand-built
// sequences for backpressure, saturation, collisions, bulk clear and async reset.
module tb_bloom_query_engine;

  localparam int DW = 160;
  localparam int HW = 72;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic [DW-1:0]  data_i = '0;
  logic [HW-1:0]  hash_i = '0;
  logic           valid_i = 1'b0;
  logic           ready_o;
  logic [31:0]    amm_address_i = '0;
  logic           amm_write_i = 1'b0;
  logic [31:0]    amm_writedata_i = '0;
  logic [3:0]     matches_cnt_o;
  logic           clean_stb = 1'b0;
  logic [DW-1:0]  suspect_data_o;
  logic           suspect_valid_o;
  logic           suspect_ready_i = 1'b0;
  logic           busy_o;

  int errors = 0;
  int checks = 0;
  int cnt_model = 0;

  bloom_query_engine #(.MATCH_CNT_W(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(data_i), .hash_i(hash_i),
    .valid_i(valid_i), .ready_o(ready_o), .amm_address_i(amm_address_i),
    .amm_write_i(amm_write_i), .amm_writedata_i(amm_writedata_i),
    .matches_cnt_o(matches_cnt_o), .matches_cnt_clean_stb_i(clean_stb),
    .suspect_data_o(suspect_data_o), .suspect_valid_o(suspect_valid_o),
    .suspect_ready_i(suspect_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [HW-1:0] hash;
    logic          hit;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [HW-1:0] hall(input int v);
    logic [HW-1:0] h;
    for (int k = 0; k < 6; k++) h[k*12 +: 12] = 12'(v);
    return h;
  endfunction

  function automatic logic [HW-1:0] hset(input logic [HW-1:0] h, input int bank, input int v);
    logic [HW-1:0] r;
    r = h;
    r[bank*12 +: 12] = 12'(v);
    return r;
  endfunction

  function automatic logic [31:0] lut_addr(input int bank, input int idx);
    return {16'h0000, 4'(bank), 12'(idx)};
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 15) ? 15 : c + 1;
  endfunction

  task automatic lut_write(input logic [31:0] a, input logic [31:0] d);
    amm_address_i = a;
    amm_writedata_i = d;
    amm_write_i = 1'b1;
    tick();
    amm_write_i = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready_o && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, ready_o, 1);
  endtask

  task automatic pop_one();
    suspect_ready_i = 1'b1;
    tick();
    suspect_ready_i = 1'b0;
  endtask

  task automatic query_one(input logic [DW-1:0] d, input logic [HW-1:0] h, input logic hit, input string tag);
    wait_ready(tag);
    data_i = d;
    hash_i = h;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    check({tag, "_early_valid"}, suspect_valid_o, 0);
    tick();
    check({tag, "_hit"}, suspect_valid_o, hit);
    if (hit) begin
      cnt_model = sat_inc(cnt_model);
      check({tag, "_data"}, suspect_data_o, d);
    end
    if (suspect_valid_o) pop_one();
    check({tag, "_cnt"}, matches_cnt_o, cnt_model);
  endtask

  // Issues the clear command on the next edge and counts cycles with busy_o high.
  task automatic run_clear(input logic inject, output int busy_n, output int ready_viol);
    amm_address_i = 32'h8000_0000;
    amm_write_i = 1'b1;
    tick();
    amm_write_i = 1'b0;
    busy_n = 0;
    ready_viol = 0;
    while (busy_o && busy_n < 5000) begin
      if (ready_o) ready_viol++;
      amm_write_i = 1'b0;
      if (inject && busy_n == 50) begin
        amm_address_i = 32'h8000_0000;
        amm_write_i = 1'b1;
      end
      if (inject && busy_n >= 100 && busy_n < 106) begin
        amm_address_i = lut_addr(busy_n - 100, 3);
        amm_writedata_i = 32'd1;
        amm_write_i = 1'b1;
      end
      busy_n++;
      tick();
    end
    amm_write_i = 1'b0;
  endtask

  initial begin
    int busy_n, viol, accepted, cycles;
    logic [DW-1:0] exp_q [$];
    logic [HW-1:0] h;

    h = hset(hall(5), 1, 9);
    h = hset(h, 3, 9);
    h = hset(h, 5, 9);
    vecs[0] = '{160'hA0, hall(5), 1'b1};
    vecs[1] = '{160'hA1, hset(hall(5), 3, 6), 1'b0};
    vecs[2] = '{160'hA2, hall(9), 1'b1};
    vecs[3] = '{160'hA3, h, 1'b1};
    vecs[4] = '{160'hA4, hset(hall(5), 2, 7), 1'b1};
    vecs[5] = '{160'hA5, hall(7), 1'b0};
    vecs[6] = '{160'hA6, hall(100), 1'b0};
    vecs[7] = '{160'hA7, hset(hall(100), 5, 5), 1'b1};

    repeat (3) tick();
    check("rst_ready", ready_o, 0);
    check("rst_valid", suspect_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", matches_cnt_o, 0);
    arst_n = 1'b1;
    #1;
    check("rel_ready_before_edge", ready_o, 0);
    tick();
    check("rel_ready_first_edge", ready_o, 1);

    run_clear(1'b0, busy_n, viol);
    check("clr0_busy_cycles", busy_n, 4096);
    check("clr0_ready_low", viol, 0);

    for (int k = 0; k < 6; k++) begin
      lut_write(lut_addr(k, 5), 32'd1);
      lut_write(lut_addr(k, 9), 32'd1);
      if (k < 5) lut_write(lut_addr(k, 100), 32'd1);
    end
    lut_write(lut_addr(2, 7), 32'd1);

    for (int i = 0; i < 8; i++) query_one(vecs[i].data, vecs[i].hash, vecs[i].hit, $sformatf("vec%0d", i));

    // Bank field 10 is out of range and must not touch bank 2.
    lut_write(lut_addr(10, 5), 32'd0);
    query_one(160'hB0, hall(5), 1'b1, "bank_oob");

    // Write lands on the same edge as the bank read: query still sees the old 1.
    wait_ready("coll");
    data_i = 160'hC0;
    hash_i = hall(5);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    amm_address_i = lut_addr(0, 5);
    amm_writedata_i = 32'd0;
    amm_write_i = 1'b1;
    tick();
    amm_write_i = 1'b0;
    tick();
    check("coll_hit_old_bit", suspect_valid_o, 1);
    cnt_model = sat_inc(cnt_model);
    if (suspect_valid_o) pop_one();
    query_one(160'hC1, hall(5), 1'b0, "coll_after");
    lut_write(lut_addr(0, 5), 32'd1);
    query_one(160'hC2, hall(5), 1'b1, "coll_restore");

    // Clean strobe on the increment edge wins.
    wait_ready("clean");
    data_i = 160'hD0;
    hash_i = hall(5);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    clean_stb = 1'b1;
    tick();
    clean_stb = 1'b0;
    check("clean_cnt", matches_cnt_o, 0);
    check("clean_push", suspect_valid_o, 1);
    cnt_model = 0;
    if (suspect_valid_o) pop_one();

    // 20 back-to-back hits with the FIFO draining: one per cycle, counter pinned at 15.
    suspect_ready_i = 1'b1;
    hash_i = hall(5);
    data_i = 160'hE0;
    valid_i = 1'b1;
    accepted = 0;
    cycles = 0;
    while (accepted < 20 && cycles < 100) begin
      if (ready_o) accepted++;
      cycles++;
      tick();
    end
    valid_i = 1'b0;
    check("thr_cycles", cycles, 20);
    repeat (4) tick();
    check("sat_cnt", matches_cnt_o, 15);
    check("sat_drained", suspect_valid_o, 0);
    suspect_ready_i = 1'b0;

    // Backpressure: 12 attempts, only 8 fit.
    clean_stb = 1'b1;
    tick();
    clean_stb = 1'b0;
    cnt_model = 0;
    for (int i = 0; i < 12; i++) begin
      data_i = 160'(256 + i);
      valid_i = 1'b1;
      if (ready_o) exp_q.push_back(data_i);
      tick();
    end
    valid_i = 1'b0;
    check("bp_accepted", exp_q.size(), 8);
    repeat (3) tick();
    check("bp_ready_low", ready_o, 0);
    check("bp_cnt", matches_cnt_o, 8);
    suspect_ready_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("bp_pop%0d_valid", j), suspect_valid_o, 1);
      check($sformatf("bp_pop%0d_data", j), suspect_data_o, (j < exp_q.size()) ? exp_q[j] : '0);
      tick();
    end
    suspect_ready_i = 1'b0;
    check("bp_empty", suspect_valid_o, 0);
    cnt_model = 8;

    // Query already in flight when the clear starts completes with the old bits.
    wait_ready("clr1");
    data_i = 160'hF0;
    hash_i = hall(5);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    run_clear(1'b1, busy_n, viol);
    check("clr1_busy_cycles", busy_n, 4096);
    check("clr1_ready_low", viol, 0);
    check("clr1_inflight_push", suspect_valid_o, 1);
    check("clr1_inflight_data", suspect_data_o, 160'hF0);
    cnt_model = sat_inc(cnt_model);
    check("clr1_cnt", matches_cnt_o, cnt_model);
    if (suspect_valid_o) pop_one();
    query_one(160'hF1, hall(5), 1'b0, "clr1_miss5");
    query_one(160'hF2, hall(9), 1'b0, "clr1_miss9");
    query_one(160'hF3, hall(3), 1'b0, "clr1_miss3");

    // Async reset mid-sweep with a queued suspect.
    for (int k = 0; k < 6; k++) lut_write(lut_addr(k, 5), 32'd1);
    query_one(160'h99, hall(5), 1'b1, "pre_rst");
    wait_ready("pre_rst2");
    data_i = 160'h9A;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    check("pre_rst_queued", suspect_valid_o, 1);
    amm_address_i = 32'h8000_0000;
    amm_write_i = 1'b1;
    tick();
    amm_write_i = 1'b0;
    repeat (50) tick();
    check("pre_rst_busy", busy_o, 1);
    arst_n = 1'b0;
    #2;
    check("arst_busy", busy_o, 0);
    check("arst_ready", ready_o, 0);
    check("arst_valid", suspect_valid_o, 0);
    check("arst_cnt", matches_cnt_o, 0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("arst_rel_ready_before_edge", ready_o, 0);
    tick();
    check("arst_rel_ready", ready_o, 1);
    check("arst_rel_busy", busy_o, 0);
    check("arst_rel_empty", suspect_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
